// File: rtl/i2c_fifo_wm.sv
// rtl/i2c_fifo_wm.sv - parametrised I2C data FIFO with watermarks, sticky error flags, flush and selectable read mode
module i2c_fifo_wm #(
   parameter int W    = 8,
   parameter int M    = 4,
   parameter int FWFT = 0
) (
   input  logic         i_clk,
   input  logic         reset,
   input  logic         flush,
   input  logic [W-1:0] wr_data,
   input  logic         wr_request,
   input  logic         rd_request,
   output logic [W-1:0] rd_data,
   output logic         rd_valid,
   output logic         empty,
   output logic         full,
   output logic [M:0]   count,
   input  logic [M:0]   af_level,
   input  logic [M:0]   ae_level,
   output logic         almost_full,
   output logic         almost_empty,
   output logic         overflow,
   output logic         underflow,
   input  logic         clear_overflow_request,
   input  logic         clear_underflow_request
);

   // Depth expressed in the occupancy width: a single MSB set.
   localparam logic [M:0] DEPTH = {1'b1, {M{1'b0}}};
   localparam int         D     = 1 << M;

   logic [W-1:0] mem [D];
   logic [M:0]   wr_ptr;
   logic [M:0]   rd_ptr;

   logic wr_accept;
   logic wr_drop;
   logic rd_accept;
   logic rd_refuse;

   // Status derives only from registered pointers; the extra pointer bit
   // distinguishes full from empty when the address bits coincide.
   always_comb begin
      count        = wr_ptr - rd_ptr;
      empty        = (count == '0);
      full         = (count == DEPTH);
      almost_full  = (count >= af_level);
      almost_empty = (count <= ae_level);
   end

   // Acceptance is decided by pre-edge occupancy; flush suppresses every request.
   always_comb begin
      wr_accept = wr_request & ~full  & ~flush;
      wr_drop   = wr_request &  full  & ~flush;
      rd_accept = rd_request & ~empty & ~flush;
      rd_refuse = rd_request &  empty & ~flush;
   end

   // Pointer update: reset beats flush, flush clears both pointers.
   always_ff @(posedge i_clk) begin
      if (reset || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_accept) wr_ptr <= wr_ptr + 1'b1;
         if (rd_accept) rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage write; contents are deliberately left unreset.
   always_ff @(posedge i_clk) begin
      if (!reset && wr_accept) mem[wr_ptr[M-1:0]] <= wr_data;
   end

   // Sticky overflow: a new drop outranks a clear; flush freezes the flag.
   always_ff @(posedge i_clk) begin
      if (reset)                       overflow <= 1'b0;
      else if (wr_drop)                overflow <= 1'b1;
      else if (!flush && clear_overflow_request) overflow <= 1'b0;
   end

   // Sticky underflow: same precedence as overflow.
   always_ff @(posedge i_clk) begin
      if (reset)                        underflow <= 1'b0;
      else if (rd_refuse)               underflow <= 1'b1;
      else if (!flush && clear_underflow_request) underflow <= 1'b0;
   end

   generate
      if (FWFT == 0) begin : g_registered
         logic [W-1:0] rd_data_q;
         logic         rd_valid_q;

         // Registered read: pop captures the head word, valid pulses for one cycle.
         always_ff @(posedge i_clk) begin
            if (reset) begin
               rd_data_q  <= '0;
               rd_valid_q <= 1'b0;
            end else if (rd_accept) begin
               rd_data_q  <= mem[rd_ptr[M-1:0]];
               rd_valid_q <= 1'b1;
            end else begin
               rd_valid_q <= 1'b0;
            end
         end

         assign rd_data  = rd_data_q;
         assign rd_valid = rd_valid_q;
      end else begin : g_fwft
         // Fall-through read: head word shown whenever the FIFO holds data.
         always_comb begin
            rd_data  = empty ? '0 : mem[rd_ptr[M-1:0]];
            rd_valid = ~empty;
         end
      end
   endgenerate

endmodule

// File: tb/tb_i2c_fifo_wm.sv
// tb/tb_i2c_fifo_wm.sv - randomized and directed bench for i2c_fifo_wm in both read modes
module tb_i2c_fifo_wm;

   logic       clk;
   logic       reset;
   logic       flush;
   logic [7:0] wr_data;
   logic       wr_request;
   logic       rd_request;
   logic [2:0] af_level;
   logic [2:0] ae_level;
   logic       clear_overflow_request;
   logic       clear_underflow_request;

   logic [7:0] rd_data0, rd_data1;
   logic       rd_valid0, rd_valid1;
   logic       empty0, empty1, full0, full1;
   logic [2:0] count0, count1;
   logic       af0, af1, ae0, ae1;
   logic       ov0, ov1, un0, un1;

   int n_cmp = 0;
   int n_bad = 0;

   // reference model
   logic [7:0] q[$];
   logic       m_ov, m_un;
   logic [7:0] m_rdd;
   logic       m_rdv;

   i2c_fifo_wm #(.W(8), .M(2), .FWFT(0)) dut0 (
      .i_clk(clk), .reset(reset), .flush(flush), .wr_data(wr_data),
      .wr_request(wr_request), .rd_request(rd_request), .rd_data(rd_data0),
      .rd_valid(rd_valid0), .empty(empty0), .full(full0), .count(count0),
      .af_level(af_level), .ae_level(ae_level), .almost_full(af0),
      .almost_empty(ae0), .overflow(ov0), .underflow(un0),
      .clear_overflow_request(clear_overflow_request),
      .clear_underflow_request(clear_underflow_request));

   i2c_fifo_wm #(.W(8), .M(2), .FWFT(1)) dut1 (
      .i_clk(clk), .reset(reset), .flush(flush), .wr_data(wr_data),
      .wr_request(wr_request), .rd_request(rd_request), .rd_data(rd_data1),
      .rd_valid(rd_valid1), .empty(empty1), .full(full1), .count(count1),
      .af_level(af_level), .ae_level(ae_level), .almost_full(af1),
      .almost_empty(ae1), .overflow(ov1), .underflow(un1),
      .clear_overflow_request(clear_overflow_request),
      .clear_underflow_request(clear_underflow_request));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] head();
      if (q.size() == 0) return 8'h00;
      return q[0];
   endfunction

   // One clock: drive after negedge, update model at posedge, return at next negedge.
   task automatic cyc(input logic w, input logic [7:0] d, input logic r,
                      input logic f, input logic rs, input logic co, input logic cu);
      int n;
      wr_request = w; wr_data = d; rd_request = r; flush = f; reset = rs;
      clear_overflow_request = co; clear_underflow_request = cu;
      @(posedge clk);
      n = q.size();
      if (rs) begin
         q.delete(); m_ov = 0; m_un = 0; m_rdd = 8'h00; m_rdv = 0;
      end else if (f) begin
         q.delete(); m_rdv = 0;
      end else begin
         m_rdv = 0;
         if (r && n > 0) begin m_rdd = q.pop_front(); m_rdv = 1; end
         if (w && n < 4) q.push_back(d);
         if (w && n == 4) m_ov = 1; else if (co) m_ov = 0;
         if (r && n == 0) m_un = 1; else if (cu) m_un = 0;
      end
      @(negedge clk);
      wr_request = 0; rd_request = 0; flush = 0; reset = 0;
      clear_overflow_request = 0; clear_underflow_request = 0;
   endtask

   task automatic test_reset();
      af_level = 3'd3; ae_level = 3'd1;
      cyc(0, 8'h00, 0, 0, 1, 0, 0);
      n_cmp++; if (count0 !== 3'd0) begin n_bad++; $display("FAIL reset_count got %0d want 0", count0); end
      n_cmp++; if (empty0 !== 1'b1 || empty1 !== 1'b1) begin n_bad++; $display("FAIL reset_empty got %b/%b want 1/1", empty0, empty1); end
      n_cmp++; if (full0 !== 1'b0) begin n_bad++; $display("FAIL reset_full got %b want 0", full0); end
      n_cmp++; if ({ov0, un0, ov1, un1} !== 4'b0000) begin n_bad++; $display("FAIL reset_flags got %b want 0000", {ov0, un0, ov1, un1}); end
      n_cmp++; if (rd_data0 !== 8'h00 || rd_valid0 !== 1'b0) begin n_bad++; $display("FAIL reset_rd0 got %h/%b want 00/0", rd_data0, rd_valid0); end
      n_cmp++; if (rd_data1 !== 8'h00 || rd_valid1 !== 1'b0) begin n_bad++; $display("FAIL reset_rd1 got %h/%b want 00/0", rd_data1, rd_valid1); end
      n_cmp++; if (ae0 !== 1'b1 || af0 !== 1'b0) begin n_bad++; $display("FAIL reset_wm got ae=%b af=%b want 1/0", ae0, af0); end
   endtask

   task automatic test_fill_overflow();
      logic [7:0] exp_v [4];
      exp_v = '{8'h11, 8'h22, 8'h33, 8'h44};
      for (int i = 0; i < 4; i++) cyc(1, exp_v[i], 0, 0, 0, 0, 0);
      n_cmp++; if (full0 !== 1'b1 || count0 !== 3'd4) begin n_bad++; $display("FAIL fill_full got full=%b count=%0d want 1/4", full0, count0); end
      cyc(1, 8'h55, 0, 0, 0, 0, 0);
      n_cmp++; if (ov0 !== 1'b1 || ov1 !== 1'b1 || count0 !== 3'd4) begin n_bad++; $display("FAIL overflow got ov=%b/%b count=%0d want 1/1/4", ov0, ov1, count0); end
      for (int i = 0; i < 4; i++) begin
         n_cmp++; if (rd_data1 !== exp_v[i]) begin n_bad++; $display("FAIL fwft_head%0d got %h want %h", i, rd_data1, exp_v[i]); end
         cyc(0, 8'h00, 1, 0, 0, 0, 0);
         n_cmp++; if (rd_data0 !== exp_v[i] || rd_valid0 !== 1'b1) begin n_bad++; $display("FAIL read%0d got %h/%b want %h/1", i, rd_data0, rd_valid0, exp_v[i]); end
      end
      n_cmp++; if (empty0 !== 1'b1) begin n_bad++; $display("FAIL drained_empty got %b want 1", empty0); end
      cyc(0, 8'h00, 0, 0, 0, 1, 0);
      n_cmp++; if (rd_valid0 !== 1'b0 || rd_data0 !== 8'h44 || ov0 !== 1'b0) begin n_bad++; $display("FAIL idle_after_read got %h/%b ov=%b want 44/0/0", rd_data0, rd_valid0, ov0); end
   endtask

   task automatic test_wrap();
      logic [7:0] d;
      cyc(1, 8'h01, 0, 0, 0, 0, 0);
      cyc(1, 8'h02, 0, 0, 0, 0, 0);
      for (int i = 0; i < 10; i++) begin
         d = 8'($urandom);
         cyc(1, d, 1, 0, 0, 0, 0);
         n_cmp++; if (count0 !== 3'd2 || full0 !== 1'b0) begin n_bad++; $display("FAIL wrap_count%0d got %0d full=%b want 2/0", i, count0, full0); end
         n_cmp++; if (rd_data0 !== m_rdd || rd_valid0 !== 1'b1) begin n_bad++; $display("FAIL wrap_data%0d got %h want %h", i, rd_data0, m_rdd); end
      end
      cyc(0, 8'h00, 1, 0, 0, 0, 0);
      cyc(0, 8'h00, 1, 0, 0, 0, 0);
   endtask

   task automatic test_underflow();
      cyc(1, 8'h5A, 1, 0, 0, 0, 0);
      n_cmp++; if (un0 !== 1'b1 || count0 !== 3'd1 || rd_valid0 !== 1'b0) begin n_bad++; $display("FAIL rd_wr_empty got un=%b count=%0d valid=%b want 1/1/0", un0, count0, rd_valid0); end
      cyc(0, 8'h00, 1, 0, 0, 0, 0);
      n_cmp++; if (rd_data0 !== 8'h5A) begin n_bad++; $display("FAIL rd_after_under got %h want 5a", rd_data0); end
      cyc(0, 8'h00, 0, 0, 0, 0, 1);
      n_cmp++; if (un0 !== 1'b0) begin n_bad++; $display("FAIL under_clear got %b want 0", un0); end
      cyc(0, 8'h00, 1, 0, 0, 0, 1);
      n_cmp++; if (un0 !== 1'b1 || un1 !== 1'b1) begin n_bad++; $display("FAIL under_set_wins got %b/%b want 1/1", un0, un1); end
      cyc(0, 8'h00, 0, 0, 0, 0, 1);
   endtask

   task automatic test_fwft();
      cyc(1, 8'hA5, 0, 0, 0, 0, 0);
      n_cmp++; if (rd_data1 !== 8'hA5 || rd_valid1 !== 1'b1) begin n_bad++; $display("FAIL fwft_show got %h/%b want a5/1", rd_data1, rd_valid1); end
      cyc(0, 8'h00, 1, 0, 0, 0, 0);
      n_cmp++; if (rd_data1 !== 8'h00 || rd_valid1 !== 1'b0 || empty1 !== 1'b1) begin n_bad++; $display("FAIL fwft_pop got %h/%b e=%b want 00/0/1", rd_data1, rd_valid1, empty1); end
   endtask

   task automatic test_watermarks();
      af_level = 3'd3; ae_level = 3'd1;
      for (int i = 0; i <= 4; i++) begin
         #1;
         n_cmp++; if (ae0 !== (i <= 1) || af0 !== (i >= 3)) begin n_bad++; $display("FAIL wm_fill%0d got ae=%b af=%b want %b/%b", i, ae0, af0, i <= 1, i >= 3); end
         if (i < 4) cyc(1, 8'(i), 0, 0, 0, 0, 0);
      end
      for (int i = 4; i >= 0; i--) begin
         #1;
         n_cmp++; if (ae1 !== (i <= 1) || af1 !== (i >= 3)) begin n_bad++; $display("FAIL wm_drain%0d got ae=%b af=%b want %b/%b", i, ae1, af1, i <= 1, i >= 3); end
         if (i > 0) cyc(0, 8'h00, 1, 0, 0, 0, 0);
      end
      af_level = 3'd0; ae_level = 3'd4;
      #1;
      n_cmp++; if (af0 !== 1'b1 || ae0 !== 1'b1) begin n_bad++; $display("FAIL wm_extremes_empty got af=%b ae=%b want 1/1", af0, ae0); end
      for (int i = 0; i < 4; i++) cyc(1, 8'(i), 0, 0, 0, 0, 0);
      n_cmp++; if (af0 !== 1'b1 || ae0 !== 1'b1) begin n_bad++; $display("FAIL wm_extremes_full got af=%b ae=%b want 1/1", af0, ae0); end
      af_level = 3'd3; ae_level = 3'd1;
   endtask

   task automatic test_flush();
      logic [7:0] held;
      cyc(0, 8'h00, 0, 0, 0, 0, 0);
      cyc(1, 8'hEE, 0, 0, 0, 0, 0);
      cyc(0, 8'h00, 1, 0, 0, 0, 0);
      held = rd_data0;
      n_cmp++; if (count0 !== 3'd3 || ov0 !== 1'b1) begin n_bad++; $display("FAIL pre_flush got count=%0d ov=%b want 3/1", count0, ov0); end
      cyc(1, 8'h77, 1, 1, 0, 1, 0);
      n_cmp++; if (count0 !== 3'd0 || empty0 !== 1'b1 || empty1 !== 1'b1) begin n_bad++; $display("FAIL flush_ptrs got count=%0d empty=%b want 0/1", count0, empty0); end
      n_cmp++; if (ov0 !== 1'b1 || un0 !== 1'b0) begin n_bad++; $display("FAIL flush_flags got ov=%b un=%b want 1/0", ov0, un0); end
      n_cmp++; if (rd_data0 !== held || rd_valid0 !== 1'b0) begin n_bad++; $display("FAIL flush_rd got %h/%b want %h/0", rd_data0, rd_valid0, held); end
      cyc(0, 8'h00, 0, 0, 0, 1, 0);
   endtask

   task automatic test_reset_mid();
      cyc(1, 8'h10, 0, 0, 0, 0, 0);
      cyc(1, 8'h20, 1, 0, 0, 0, 0);
      cyc(1, 8'h30, 1, 0, 0, 0, 0);
      cyc(1, 8'h40, 1, 1, 1, 0, 0);
      n_cmp++; if (count0 !== 3'd0 || empty0 !== 1'b1 || full0 !== 1'b0) begin n_bad++; $display("FAIL reset_mid_ptrs got count=%0d e=%b f=%b want 0/1/0", count0, empty0, full0); end
      n_cmp++; if (rd_data0 !== 8'h00 || rd_valid0 !== 1'b0 || rd_valid1 !== 1'b0 || un0 !== 1'b0) begin n_bad++; $display("FAIL reset_mid_rd got %h/%b/%b un=%b want 00/0/0/0", rd_data0, rd_valid0, rd_valid1, un0); end
   endtask

   task automatic test_random();
      int bad_before;
      for (int i = 0; i < 600; i++) begin
         if (i % 60 == 0) begin
            af_level = 3'($urandom_range(0, 7));
            ae_level = 3'($urandom_range(0, 7));
         end
         cyc($urandom_range(0, 9) < 6, 8'($urandom), $urandom_range(0, 9) < 5,
             $urandom_range(0, 39) == 0, 0,
             $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
         bad_before = n_bad;
         n_cmp++; if (count0 !== 3'(q.size()) || count1 !== 3'(q.size())) begin n_bad++; $display("FAIL rnd_count@%0d got %0d/%0d want %0d", i, count0, count1, q.size()); end
         n_cmp++; if (empty0 !== (q.size() == 0) || full0 !== (q.size() == 4)) begin n_bad++; $display("FAIL rnd_ef@%0d got e=%b f=%b size=%0d", i, empty0, full0, q.size()); end
         n_cmp++; if (af0 !== (q.size() >= int'(af_level)) || ae0 !== (q.size() <= int'(ae_level))) begin n_bad++; $display("FAIL rnd_wm@%0d got af=%b ae=%b size=%0d af_l=%0d ae_l=%0d", i, af0, ae0, q.size(), af_level, ae_level); end
         n_cmp++; if (ov0 !== m_ov || un0 !== m_un || ov1 !== m_ov || un1 !== m_un) begin n_bad++; $display("FAIL rnd_flags@%0d got ov=%b un=%b want %b/%b", i, ov0, un0, m_ov, m_un); end
         n_cmp++; if (rd_valid0 !== m_rdv || (m_rdv && rd_data0 !== m_rdd)) begin n_bad++; $display("FAIL rnd_rd0@%0d got %h/%b want %h/%b", i, rd_data0, rd_valid0, m_rdd, m_rdv); end
         n_cmp++; if (rd_data1 !== head() || rd_valid1 !== (q.size() != 0)) begin n_bad++; $display("FAIL rnd_rd1@%0d got %h/%b want %h", i, rd_data1, rd_valid1, head()); end
         if (n_bad - bad_before > 0 && n_bad > 40) break;
      end
   endtask

   initial begin
      reset = 1; flush = 0; wr_data = 0; wr_request = 0; rd_request = 0;
      af_level = 3'd3; ae_level = 3'd1;
      clear_overflow_request = 0; clear_underflow_request = 0;
      q.delete(); m_ov = 0; m_un = 0; m_rdd = 0; m_rdv = 0;
      @(negedge clk);
      test_reset();
      test_fill_overflow();
      test_wrap();
      test_underflow();
      test_fwft();
      test_watermarks();
      test_flush();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/i2c_fifo_wm.md
# i2c_fifo_wm

Parametrised FIFO for the I2C core's TX and RX data paths. It replaces the fixed-depth FIFO with:
- full 2**M storage and an occupancy count;
- programmable almost-full/almost-empty watermarks for interrupt and DMA pacing;
- sticky overflow and underflow flags;
- a synchronous flush;
- a compile-time choice of registered or first-word-fall-through read.

It sits between the register/bus interface and the I2C byte engine, one instance per direction.

## Interface
- W, 8, data word width in bits
- M, 4, log2 of depth; depth D = 2**M, M >= 1
- FWFT, 0, read mode: 0 = registered read, 1 = first-word-fall-through
- i_clk  in  1  clock, all logic on rising edge
- reset  in  1  reset, synchronous, active-high
- flush  in  1  synchronous pointer clear
- wr_data  in  W  write word
- wr_request  in  1  push request
- rd_request  in  1  pop request
- rd_data  out  W  read word
- rd_valid  out  1  rd_data holds a newly popped word (FWFT=0); equals !empty (FWFT=1)
- empty  out  1  count == 0
- full  out  1  count == D
- count  out  M+1  occupancy, 0..D
- af_level  in  M+1  almost-full threshold
- ae_level  in  M+1  almost-empty threshold
- almost_full  out  1  count >= af_level
- almost_empty  out  1  count <= ae_level
- overflow  out  1  sticky: write attempted while full
- underflow  out  1  sticky: read attempted while empty
- clear_overflow_request  in  1  clears overflow
- clear_underflow_request  in  1  clears underflow

## Operation
- Storage is D words. The write and read pointers are M+1 bits, wrapping modulo 2**(M+1).
- Memory address = pointer[M-1:0]; count = wr_ptr - rd_ptr, (M+1)-bit modular arithmetic.
- empty, full, almost_full and almost_empty are combinational from the registered pointers only, never from the current request inputs.
- Write accepted iff wr_request & !full & !flush: mem[wr_ptr] <= wr_data; wr_ptr++.
- Write attempted while full (and not flush): word dropped, overflow <= 1.
- Read accepted iff rd_request & !empty & !flush: rd_ptr++.
- Read attempted while empty (and not flush): no pointer change, underflow <= 1.
- Simultaneous read+write with 0 < count < D: both accepted, count unchanged.
- Simultaneous read+write when full: read accepted, write dropped, overflow set.
- Simultaneous read+write when empty: write accepted, read refused, underflow set.
- Occupancy before the edge decides every acceptance.
- Sticky flag update, same cycle as its clear request: the set wins; otherwise the request clears the flag.
- Writes are not blocked while overflow is set; only full blocks them.
- flush = 1: wr_ptr = rd_ptr = 0 at the edge.
  - Requests in that cycle are ignored and set no flags.
  - overflow and underflow keep their values.
  - rd_data is unchanged in FWFT=0.
- FWFT=0: on an accepted read, rd_data <= mem[rd_ptr] and rd_valid is 1 the next cycle. Otherwise rd_valid = 0 and rd_data holds its value.
- FWFT=1: rd_data = empty ? 0 : mem[rd_ptr[M-1:0]], combinational. rd_valid = !empty. rd_request pops the displayed word.
- Watermarks are compared unsigned against count every cycle. af_level = 0 makes almost_full constant 1. ae_level >= D makes almost_empty constant 1.
- Memory contents are not reset.

## Timing
- Reset values:
  - pointers 0, count 0
  - empty 1, full 0
  - overflow 0, underflow 0
  - rd_data 0, rd_valid 0 (FWFT=0) / 1-cycle-combinational !empty (FWFT=1)
  - almost_empty 1, almost_full = (af_level == 0)
- reset has priority over flush and all requests. Asserting it mid-burst discards contents at that edge.
- Write at edge k:
  - count, empty, full and the watermark flags reflect the write from cycle k+1.
  - FWFT=1: the word appears on rd_data in cycle k+1.
- FWFT=0 read issued in cycle k: rd_data/rd_valid updated at edge k, valid for exactly one cycle unless another read follows. Latency is one cycle.
- Back-to-back reads every cycle are sustained at one word per clock in both modes.
- The overflow/underflow set is visible the cycle after the offending request.

## Test plan
- W=8, M=2, FWFT=0: write 0x11,0x22,0x33,0x44 on consecutive cycles -> full=1, count=4. A 5th write 0x55 -> overflow=1, count stays 4. Four reads -> rd_data 0x11,0x22,0x33,0x44, each with rd_valid, then empty=1.
- Wrap-around: 10 cycles of simultaneous write+read at count=2 -> count stays 2, data order preserved across pointer wrap, full never asserts.
- Read when empty plus write same cycle -> underflow=1, count=1, pointer unchanged. clear_underflow_request with no new event -> underflow=0 next cycle. Clear coincident with a new empty read -> underflow stays 1.
- FWFT=1: write 0xA5 at edge k -> rd_data=0xA5 and rd_valid=1 in cycle k+1 without any read. rd_request pops it -> empty=1, rd_data=0.
- Watermarks af_level=3, ae_level=1: fill 0->4 -> almost_empty high at counts 0,1, low at 2; almost_full high from count 3. Drain reverses both.
- flush at count=3 with concurrent wr_request and rd_request -> count=0, empty=1, no flag change. reset mid-fill -> all outputs at reset values next cycle.
